// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets several AXI-Stream byte sources share one uart_tx.
// A source keeps the grant for a whole tlast-delimited message and its bytes pass through one output register.
module uart_tx_arb #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    input  logic [PORTS-1:0]              s_axis_tlast,
    output logic [PORTS-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [PORTS-1:0]              grant,
    output logic [$clog2(PORTS)-1:0]      grant_idx,
    output logic                          overrun
);

    localparam int IDX_W    = $clog2(PORTS);
    localparam int BEAT_W   = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam int LIMIT_M1 = (MAX_BEATS > 0) ? MAX_BEATS - 1 : 0;
    localparam int SAT_VAL  = (MAX_BEATS > 0) ? MAX_BEATS : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LIMIT_M1);
    localparam logic [BEAT_W-1:0] BEAT_SAT  = BEAT_W'(SAT_VAL);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(PORTS - 1);
    localparam logic [PORTS-1:0]  ONE_HOT0  = {{(PORTS-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state_r;
    logic [PORTS-1:0]      grant_r;
    logic [IDX_W-1:0]      grant_idx_r;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic                  overrun_r;
    logic [DATA_WIDTH-1:0] m_tdata_r;
    logic                  m_tvalid_r;

    logic                  out_free_s;
    logic                  owner_valid_s;
    logic                  owner_last_s;
    logic [DATA_WIDTH-1:0] owner_data_s;
    logic                  accept_s;
    logic                  force_rel_s;
    logic [BEAT_W-1:0]     beat_inc_s;
    logic                  found_s;
    logic [IDX_W-1:0]      winner_s;
    logic [PORTS-1:0]      s_tready_s;

    // The output register can take a byte when empty or when it is being drained this cycle.
    assign out_free_s = !m_tvalid_r || m_axis_tready;

    // Select the current owner's stream; a one-hot compare keeps non-owner inputs out of the ready path.
    always_comb begin
        owner_data_s  = '0;
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            owner_data_s  = owner_data_s
                          | ((grant_idx_r == IDX_W'(i)) ? s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] : '0);
            owner_valid_s = owner_valid_s | ((grant_idx_r == IDX_W'(i)) && s_axis_tvalid[i]);
            owner_last_s  = owner_last_s  | ((grant_idx_r == IDX_W'(i)) && s_axis_tlast[i]);
        end
    end

    assign accept_s    = (state_r == ST_GRANT) && out_free_s && owner_valid_s;
    assign force_rel_s = (MAX_BEATS > 0) && accept_s && !owner_last_s && (beat_cnt_r == BEAT_LAST);
    assign beat_inc_s  = (beat_cnt_r == BEAT_SAT) ? beat_cnt_r : beat_cnt_r + 1'b1;

    // Round-robin search starting just after the last owner, wrapping modulo PORTS.
    always_comb begin
        int               raw_v;
        logic [IDX_W-1:0] cand_v;
        logic             hit_v;
        found_s  = 1'b0;
        winner_s = grant_idx_r;
        raw_v    = 0;
        cand_v   = '0;
        hit_v    = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            raw_v    = int'(grant_idx_r) + k;
            cand_v   = (raw_v >= PORTS) ? IDX_W'(raw_v - PORTS) : IDX_W'(raw_v);
            hit_v    = !found_s && s_axis_tvalid[cand_v];
            winner_s = hit_v ? cand_v : winner_s;
            found_s  = found_s | hit_v;
        end
    end

    // Only the owner sees ready, and only while the output register can accept.
    always_comb begin
        s_tready_s = '0;
        s_tready_s[grant_idx_r] = (state_r == ST_GRANT) && out_free_s;
    end

    // Grant FSM: arbitrate in IDLE, hold the owner until tlast or the beat limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            grant_idx_r <= IDX_MAX;
            beat_cnt_r  <= '0;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r     <= ST_GRANT;
                        grant_r     <= ONE_HOT0 << winner_s;
                        grant_idx_r <= winner_s;
                        beat_cnt_r  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (accept_s) begin
                        beat_cnt_r <= beat_inc_s;
                        if (owner_last_s || force_rel_s) begin
                            state_r   <= ST_IDLE;
                            grant_r   <= '0;
                            overrun_r <= force_rel_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Output register: load on an accepted beat, otherwise clear once downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata_r  <= '0;
            m_tvalid_r <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= owner_data_s;
            m_tvalid_r <= 1'b1;
        end else if (m_axis_tready && m_tvalid_r) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign s_axis_tready = s_tready_s;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign grant         = grant_r;
    assign grant_idx     = grant_idx_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-port byte queues feed the arbiter; a round-robin message model
// predicts grant order, byte order and forced releases, checked as the DUT runs.
module tb_uart_tx_arb;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int MAXB  = 4;
    localparam int DEPTH = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tlast;
    logic [PORTS-1:0]      s_tready;
    logic [DW-1:0]         m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [PORTS-1:0]      grant;
    logic [1:0]            grant_idx;
    logic                  overrun;

    uart_tx_arb #(.PORTS(PORTS), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .grant(grant), .grant_idx(grant_idx), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem_d [PORTS][DEPTH];
    logic       mem_l [PORTS][DEPTH];
    int         head [PORTS];
    int         tail [PORTS];
    logic [PORTS-1:0] gate;
    logic [PORTS-1:0] fire;
    int         rdy_mode;

    logic [7:0] exp_q[$];
    int         exp_grant[$];
    int         model_last;
    int         ovr_exp;
    int         ovr_seen;
    int         cur_own;
    logic [PORTS-1:0] prev_grant;
    int         idle_run;
    bit         first_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l);
        mem_d[p][tail[p]] = d;
        mem_l[p][tail[p]] = l;
        tail[p]++;
    endtask

    task automatic drive();
        for (int i = 0; i < PORTS; i++) begin
            if (head[i] < tail[i]) begin
                s_tvalid[i]          = !gate[i];
                s_tdata[i*DW +: DW]  = mem_d[i][head[i]];
                s_tlast[i]           = mem_l[i][head[i]];
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = 8'h00;
                s_tlast[i]           = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            2:       m_tready = 1'b0;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Message-level model: rotate from the last owner, hand out whole messages cut at MAXB bytes.
    task automatic plan();
        int  h [PORTS];
        int  p;
        int  n;
        bit  any;
        bit  lst;
        for (int i = 0; i < PORTS; i++) h[i] = head[i];
        forever begin
            any = 0;
            p = 0;
            for (int k = 1; k <= PORTS; k++) begin
                int c;
                c = (model_last + k) % PORTS;
                if (!any && h[c] < tail[c]) begin
                    any = 1;
                    p = c;
                end
            end
            if (!any) break;
            exp_grant.push_back(p);
            n = 0;
            forever begin
                exp_q.push_back(mem_d[p][h[p]]);
                lst = mem_l[p][h[p]];
                h[p]++;
                n++;
                if (lst) break;
                if (n == MAXB) begin
                    ovr_exp++;
                    break;
                end
                if (h[p] >= tail[p]) break;
            end
            model_last = p;
        end
    endtask

    task automatic cycle();
        logic [PORTS-1:0] own_mask;
        int p;
        @(negedge clk);
        if (prev_grant == '0 && grant != '0) begin
            chk("grant_expected", exp_grant.size() > 0, 1);
            if (exp_grant.size() > 0) begin
                p = exp_grant.pop_front();
                chk("grant_onehot", grant, 32'(1) << p);
                chk("grant_idx", grant_idx, p);
                if (!first_grant) chk("idle_gap", idle_run, 1);
                first_grant = 0;
                cur_own = p;
            end
        end else if (grant == '0 && prev_grant != '0) begin
            cur_own = -1;
        end
        idle_run   = (grant == '0) ? idle_run + 1 : 0;
        prev_grant = grant;
        own_mask   = (cur_own >= 0) ? PORTS'(1 << cur_own) : '0;
        chk("tready_nonowner", s_tready & ~own_mask, 0);
        fire = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            chk("out_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("out_byte", m_tdata, exp_q.pop_front());
        end
        if (overrun) ovr_seen++;
        @(posedge clk);
        #1;
        for (int i = 0; i < PORTS; i++) if (fire[i]) head[i]++;
        drive();
    endtask

    task automatic run_phase(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        first_grant = 1;
        done = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = (exp_q.size() == 0) && !m_tvalid && (grant == '0);
            for (int i = 0; i < PORTS; i++) if (head[i] < tail[i]) done = 0;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_grants_left"}, exp_grant.size(), 0);
        chk({name, "_overruns"}, ovr_seen, ovr_exp);
        ovr_seen = 0;
        ovr_exp  = 0;
        for (int i = 0; i < PORTS; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        exp_grant.delete();
        model_last = PORTS - 1;
        cur_own    = -1;
        prev_grant = '0;
        idle_run   = 0;
        ovr_seen   = 0;
        ovr_exp    = 0;
        gate       = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        gate = '0;
        rdy_mode = 0;
        for (int i = 0; i < PORTS; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive();
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_grant_idx", grant_idx, PORTS - 1);
        chk("rst_tready", s_tready, 0);
        chk("rst_overrun", overrun, 0);
        do_reset();

        // Asynchronous reset in the middle of a message.
        for (int b = 0; b < 5; b++) push(0, 8'h90 + 8'(b), b == 4);
        plan();
        drive();
        repeat (3) cycle();
        chk("pre_rst_tvalid", m_tvalid, 1);
        chk("pre_rst_grant", grant, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tvalid", m_tvalid, 0);
        chk("async_rst_grant", grant, 0);
        chk("async_rst_tready", s_tready, 0);
        chk("async_rst_idx", grant_idx, PORTS - 1);
        do_reset();

        // Two 3-byte messages on ports 0 and 2.
        for (int b = 0; b < 3; b++) push(0, 8'hA0 + 8'(b), b == 2);
        for (int b = 0; b < 3; b++) push(2, 8'hC0 + 8'(b), b == 2);
        plan();
        drive();
        run_phase("two_msgs", 200);

        // All ports with one-byte messages: strict rotation from port 0.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < PORTS; i++) push(i, 8'(16 * i + r), 1'b1);
        plan();
        drive();
        run_phase("rotation", 200);

        // Output stalled with 0x55 loaded.
        rdy_mode = 2;
        do_reset();
        push(1, 8'h55, 1'b0);
        push(1, 8'h66, 1'b1);
        plan();
        drive();
        n = 0;
        while (!m_tvalid && n < 10) begin
            cycle();
            n++;
        end
        chk("stall_loaded", m_tvalid, 1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("stall_tdata", m_tdata, 8'h55);
            chk("stall_tvalid", m_tvalid, 1);
            chk("stall_owner_tready", s_tready[1], 0);
        end
        rdy_mode = 0;
        drive();
        run_phase("stall", 200);

        // Beat limit: port 1 sends 6 bytes, port 2 gets in after the forced release.
        do_reset();
        for (int b = 0; b < 6; b++) push(1, 8'h10 + 8'(b), b == 5);
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b1);
        plan();
        chk("beat_limit_plan", ovr_exp, 1);
        drive();
        run_phase("beat_limit", 200);

        // Owner pauses mid-message while port 3 waits.
        do_reset();
        for (int b = 0; b < 3; b++) push(0, 8'h40 + 8'(b), b == 2);
        push(3, 8'h70, 1'b1);
        plan();
        drive();
        n = 0;
        while (head[0] < 1 && n < 10) begin
            cycle();
            n++;
        end
        chk("pause_started", head[0], 1);
        gate[0] = 1'b1;
        drive();
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("pause_grant", grant, 4'b0001);
            chk("pause_p3_tready", s_tready[3], 0);
        end
        gate[0] = 1'b0;
        drive();
        run_phase("pause", 200);

        // Randomized message mixes with random downstream backpressure.
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < PORTS; i++) begin
                int msgs;
                msgs = $urandom_range(0, 3);
                for (int m = 0; m < msgs; m++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            plan();
            drive();
            run_phase("random", 2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
